data_bus_buffer_sync: RTL and testbench
=======================================

// Module: data_bus_buffer_sync
// PURPOSE
//  Clocked, parametrised successor of the PIC data bus buffer. Sits between the CPU data bus (Ds)
//  and the Write/Read + Control logic. Write bytes are edge-captured into a show-ahead FIFO that
//  control drains with a valid/ready handshake. Reads run a request/ack handshake with control,
//  with a timeout. Ds is driven only while a completed read is held.
// PARAMETERS
//  DATA_W      8   data bus width in bits
//  FIFO_DEPTH  4   write FIFO entries; power of 2, >= 2
//  RD_TIMEOUT  16  cycles to wait for ctrl_rd_ack before timeout; >= 1
// PORTS
//  clk              in     1                        single clock, rising edge
//  rst_n            in     1                        asynchronous, active-low reset
//  Ds               inout  DATA_W                   CPU data bus; tri-state unless driving
//  RD_flag          in     1                        read strobe from Write/Read logic; synchronous to clk
//  WR_flag          in     1                        write strobe from Write/Read logic; synchronous to clk
//  Ds_from_control  in     DATA_W                   read data from Control
//  ctrl_rd_ack      in     1                        Control: Ds_from_control valid this cycle
//  RD_flag_control  out    1                        one-cycle read request to Control
//  Ds_to_Control    out    DATA_W                   FIFO head (show-ahead)
//  wr_valid         out    1                        FIFO non-empty
//  wr_ready         in     1                        Control pops head when wr_valid & wr_ready
//  fifo_count       out    $clog2(FIFO_DEPTH)+1     current FIFO occupancy
//  overflow         out    1                        sticky: write dropped because FIFO was full
//  rd_timeout       out    1                        sticky: read ack timed out
//  err_clr          in     1                        clears overflow and rd_timeout next cycle
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty; fifo_count=0, wr_valid=0, Ds_to_Control=0;
//   RD_flag_control=0, overflow=0, rd_timeout=0; read FSM=R_IDLE; Ds released (z); edge regs=0.
//  Reset mid-transfer: FIFO contents and pending read are discarded; Ds released at once (async).
//  Write path:
//   - push on WR_flag rising edge (WR_flag=1, previous cycle 0), Ds sampled in that cycle.
//   - push at edge N -> wr_valid=1 and data on Ds_to_Control at N+1. Level-held WR_flag = one push.
//   - pop: wr_valid & wr_ready at edge -> head advances; empty -> pop ignored.
//   - full & push & pop same cycle: both performed, no overflow. full & push, no pop: byte dropped,
//     overflow set. Pointers wrap modulo FIFO_DEPTH. err_clr and overflow set in same cycle: set wins.
//   - WR_flag edge suppressed while read FSM != R_IDLE or RD_flag=1 (read has priority).
//  Read FSM:
//   - R_IDLE: RD_flag rising edge -> R_REQ.
//   - R_REQ: RD_flag_control=1 for exactly this cycle -> R_WAIT; timer cleared.
//   - R_WAIT: ctrl_rd_ack=1 -> latch Ds_from_control -> R_DRIVE.
//     Timer reaches RD_TIMEOUT -> latch {DATA_W{1'b1}}, set rd_timeout -> R_DRIVE.
//   - R_DRIVE: Ds = latched byte; RD_flag=0 -> R_IDLE, Ds released in the same cycle.
//   - RD_flag falls in R_REQ/R_WAIT -> R_IDLE, no drive, late ack ignored.
//   - ctrl_rd_ack outside R_WAIT is ignored.
//  Ds is driven only in R_DRIVE; all other states z. Latency: RD edge at N -> request at N+1;
//   earliest drive at N+3 (ack in N+2).
// CONFIGURATION
//  DATA_BUS_PARITY_EN defined:
//   - FIFO entries are DATA_W+1 wide, storing odd parity of the written byte.
//   - Extra output Ds_parity_to_Control (1 bit) gives head parity; 0 when FIFO empty/reset.
//  DATA_BUS_PARITY_EN not defined: port and storage absent; behaviour otherwise identical.
// TESTING
//  1) Reset; WR_flag pulse with Ds=8'hF0 -> next cycle wr_valid=1, Ds_to_Control=8'hF0,
//     fifo_count=1; pop -> fifo_count=0.
//  2) 5 write pulses 8'h01..8'h05, no pops (DEPTH 4) -> count=4, overflow=1; pops return 01..04.
//     err_clr -> overflow=0.
//  3) Full FIFO, push 8'hAA with wr_ready=1 same cycle -> count stays 4, overflow=0, AA at tail.
//  4) RD_flag rise; ack 2 cycles after request with Ds_from_control=8'h0F -> one-cycle
//     RD_flag_control; Ds=8'h0F until RD_flag falls, then z.
//  5) RD_flag held, no ack -> after 16 wait cycles rd_timeout=1, Ds=8'hFF. RD_flag drops in
//     R_WAIT -> Ds stays z.
//  6) rst_n low during R_DRIVE with 3 FIFO entries -> Ds z immediately, count=0, wr_valid=0.
//     With DATA_BUS_PARITY_EN, write 8'h07 -> Ds_parity_to_Control=0.

Source files
------------

// File: rtl/data_bus_buffer_sync.sv
// Clocked CPU data-bus buffer: edge-captured write bytes feed a show-ahead FIFO, reads use a
// request/ack handshake with timeout. Define DATA_BUS_PARITY_EN to store and expose head parity.
module data_bus_buffer_sync #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int RD_TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   inout  wire  [DATA_W-1:0]           Ds,
   input  logic                        RD_flag,
   input  logic                        WR_flag,
   input  logic [DATA_W-1:0]           Ds_from_control,
   input  logic                        ctrl_rd_ack,
   output logic                        RD_flag_control,
   output logic [DATA_W-1:0]           Ds_to_Control,
   output logic                        wr_valid,
   input  logic                        wr_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        rd_timeout,
   input  logic                        err_clr
`ifdef DATA_BUS_PARITY_EN
   ,
   output logic                        Ds_parity_to_Control
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(RD_TIMEOUT + 1);
`ifdef DATA_BUS_PARITY_EN
   localparam int EW = DATA_W + 1;
`else
   localparam int EW = DATA_W;
`endif
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
   localparam logic [TW-1:0] TIMER_LAST = TW'(RD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_REQ   = 2'd1,
      R_WAIT  = 2'd2,
      R_DRIVE = 2'd3
   } rd_state_t;

   rd_state_t         rd_state_r, rd_state_s;
   logic              rd_prev_r, wr_prev_r;
   logic [TW-1:0]     timer_r, timer_s;
   logic [DATA_W-1:0] rd_data_r, latch_val_s;
   logic              rd_req_r, drive_r, rd_timeout_r, overflow_r;
   logic              rd_req_s, drive_s, latch_en_s, timeout_set_s;
   logic [EW-1:0]     mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
   logic [CW-1:0]     count_r, count_s;
   logic [EW-1:0]     head_r, head_s, din_s;
   logic              wr_valid_r;
   logic              rd_rise_s, wr_rise_s, push_s, pop_s, full_s, do_push_s, drop_s;

`ifdef DATA_BUS_PARITY_EN
   function automatic logic odd_parity(input logic [DATA_W-1:0] data);
      return ~(^data);
   endfunction

   assign din_s = {odd_parity(Ds), Ds};
   assign Ds_parity_to_Control = head_r[DATA_W];
`else
   assign din_s = Ds;
`endif

   // Writes are only accepted while the read side is completely idle
   assign rd_rise_s = RD_flag & ~rd_prev_r;
   assign wr_rise_s = WR_flag & ~wr_prev_r;
   assign push_s    = wr_rise_s & ~RD_flag & (rd_state_r == R_IDLE);
   assign pop_s     = wr_valid_r & wr_ready;
   assign full_s    = (count_r == CNT_FULL);
   assign do_push_s = push_s & (~full_s | pop_s);
   assign drop_s    = push_s & full_s & ~pop_s;

   // Strobe history for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_prev_r <= 1'b0;
         wr_prev_r <= 1'b0;
      end else begin
         rd_prev_r <= RD_flag;
         wr_prev_r <= WR_flag;
      end
   end

   // FIFO pointer/count/head next-state; head is precomputed so the output is a register
   always_comb begin
      if (do_push_s) wr_ptr_s = wr_ptr_r + PTR_ONE;
      else           wr_ptr_s = wr_ptr_r;
      if (pop_s) rd_ptr_s = rd_ptr_r + PTR_ONE;
      else       rd_ptr_s = rd_ptr_r;
      case ({do_push_s, pop_s})
         2'b10:   count_s = count_r + CNT_ONE;
         2'b01:   count_s = count_r - CNT_ONE;
         default: count_s = count_r;
      endcase
      if (count_s == CNT_ZERO)                        head_s = {EW{1'b0}};
      else if (do_push_s && (wr_ptr_r == rd_ptr_s))   head_s = din_s;
      else                                            head_s = mem_r[rd_ptr_s];
   end

   // FIFO storage and registered status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {EW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= CNT_ZERO;
         head_r     <= {EW{1'b0}};
         wr_valid_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (do_push_s) mem_r[wr_ptr_r] <= din_s;
         wr_ptr_r   <= wr_ptr_s;
         rd_ptr_r   <= rd_ptr_s;
         count_r    <= count_s;
         head_r     <= head_s;
         wr_valid_r <= (count_s != CNT_ZERO);
         if (drop_s)       overflow_r <= 1'b1;
         else if (err_clr) overflow_r <= 1'b0;
      end
   end

   // Read FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_state_r <= R_IDLE;
      else        rd_state_r <= rd_state_s;
   end

   // Read FSM next state; a dropped RD_flag always wins over a same-cycle ack
   always_comb begin
      rd_state_s = rd_state_r;
      case (rd_state_r)
         R_IDLE:  if (rd_rise_s) rd_state_s = R_REQ;   else rd_state_s = R_IDLE;
         R_REQ:   if (!RD_flag)  rd_state_s = R_IDLE;  else rd_state_s = R_WAIT;
         R_WAIT: begin
            if (!RD_flag)                                     rd_state_s = R_IDLE;
            else if (ctrl_rd_ack || (timer_r == TIMER_LAST))  rd_state_s = R_DRIVE;
            else                                              rd_state_s = R_WAIT;
         end
         R_DRIVE: if (!RD_flag)  rd_state_s = R_IDLE;  else rd_state_s = R_DRIVE;
         default: rd_state_s = R_IDLE;
      endcase
   end

   // Read FSM outputs, decoded from the next state so they can be registered
   always_comb begin
      rd_req_s      = (rd_state_s == R_REQ);
      drive_s       = (rd_state_s == R_DRIVE);
      if (rd_state_r == R_WAIT) timer_s = timer_r + TIMER_ONE;
      else                      timer_s = TIMER_ZERO;
      latch_en_s    = (rd_state_r == R_WAIT) & RD_flag & (ctrl_rd_ack | (timer_r == TIMER_LAST));
      if (ctrl_rd_ack) latch_val_s = Ds_from_control;
      else             latch_val_s = {DATA_W{1'b1}};
      timeout_set_s = latch_en_s & ~ctrl_rd_ack;
   end

   // Read-side registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_r      <= TIMER_ZERO;
         rd_data_r    <= {DATA_W{1'b0}};
         rd_req_r     <= 1'b0;
         drive_r      <= 1'b0;
         rd_timeout_r <= 1'b0;
      end else begin
         timer_r  <= timer_s;
         rd_req_r <= rd_req_s;
         drive_r  <= drive_s;
         if (latch_en_s) rd_data_r <= latch_val_s;
         if (timeout_set_s) rd_timeout_r <= 1'b1;
         else if (err_clr)  rd_timeout_r <= 1'b0;
      end
   end

   // Bus is released combinationally as soon as RD_flag drops
   assign Ds = (drive_r && RD_flag) ? rd_data_r : {DATA_W{1'bz}};

   assign RD_flag_control = rd_req_r;
   assign Ds_to_Control   = head_r[DATA_W-1:0];
   assign wr_valid        = wr_valid_r;
   assign fifo_count      = count_r;
   assign overflow        = overflow_r;
   assign rd_timeout      = rd_timeout_r;

endmodule

// File: tb/tb_data_bus_buffer_sync.sv
// Self-checking bench for data_bus_buffer_sync: queue-based FIFO model plus timed read transactions.
module tb_data_bus_buffer_sync;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, RD_flag, WR_flag, ctrl_rd_ack, wr_ready, err_clr, tb_oe;
   logic [7:0] Ds_from_control, tb_val, Ds_to_Control;
   logic       RD_flag_control, wr_valid, overflow, rd_timeout;
   logic [2:0] fifo_count;
   wire  [7:0] Ds;
   assign Ds = tb_oe ? tb_val : 8'bzzzz_zzzz;
`ifdef DATA_BUS_PARITY_EN
   logic       Ds_parity_to_Control;
`endif

   int errors = 0;
   int checks = 0;
   logic [7:0] q[$];
   logic m_ovf, m_rto, m_wr_prev;

   data_bus_buffer_sync #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .RD_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .Ds(Ds), .RD_flag(RD_flag), .WR_flag(WR_flag),
      .Ds_from_control(Ds_from_control), .ctrl_rd_ack(ctrl_rd_ack),
      .RD_flag_control(RD_flag_control), .Ds_to_Control(Ds_to_Control), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .fifo_count(fifo_count), .overflow(overflow),
      .rd_timeout(rd_timeout), .err_clr(err_clr)
`ifdef DATA_BUS_PARITY_EN
      , .Ds_parity_to_Control(Ds_parity_to_Control)
`endif
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      m_wr_prev = WR_flag;
      @(posedge clk);
      #1;
   endtask

   // One idle-read cycle of write/pop stimulus, compared against the queue model
   task automatic fifo_cycle(input logic wr, input logic [7:0] d, input logic rdy, input logic clr);
      logic push, pop, drop, exp_par;
      logic [7:0] exp_head;
      WR_flag = wr; RD_flag = 1'b0; ctrl_rd_ack = 1'b0;
      tb_oe = 1'b1; tb_val = d; wr_ready = rdy; err_clr = clr;
      push = wr && !m_wr_prev;
      pop  = (q.size() != 0) && rdy;
      drop = push && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(d);
      if (drop) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (clr) m_rto = 1'b0;
      tick();
      exp_head = (q.size() != 0) ? q[0] : 8'h00;
      exp_par  = (q.size() != 0) ? ~(^q[0]) : 1'b0;
      checks++; if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL fifo_count: got %0d expected %0d", fifo_count, q.size()); end
      checks++; if (wr_valid !== (q.size() != 0)) begin errors++; $display("FAIL wr_valid: got %b expected %b", wr_valid, (q.size() != 0)); end
      checks++; if (Ds_to_Control !== exp_head) begin errors++; $display("FAIL head: got %h expected %h", Ds_to_Control, exp_head); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL overflow: got %b expected %b", overflow, m_ovf); end
      checks++; if (rd_timeout !== m_rto) begin errors++; $display("FAIL rd_timeout: got %b expected %b", rd_timeout, m_rto); end
      checks++; if (RD_flag_control !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", RD_flag_control); end
`ifdef DATA_BUS_PARITY_EN
      checks++; if (Ds_parity_to_Control !== exp_par) begin errors++; $display("FAIL parity: got %b expected %b", Ds_parity_to_Control, exp_par); end
`else
      exp_par = 1'b0;
`endif
   endtask

   // Full read: ack after d wait cycles (d >= TMO means no ack), hold the drive for 'hold' cycles
   task automatic read_txn(input int d, input logic [7:0] data, input int hold);
      int cnt0;
      logic [7:0] exp;
      cnt0 = q.size();
      ctrl_rd_ack = 1'b0; wr_ready = 1'b0; err_clr = 1'b0; tb_oe = 1'b1; tb_val = 8'h00;
      RD_flag = 1'b1; WR_flag = 1'b1;
      tick();
      checks++; if (RD_flag_control !== 1'b1) begin errors++; $display("FAIL rd_req: got %b expected 1", RD_flag_control); end
      WR_flag = 1'b0;
      tick();
      checks++; if (RD_flag_control !== 1'b0) begin errors++; $display("FAIL rd_req_len: got %b expected 0", RD_flag_control); end
      for (int i = 0; i < TMO; i++) begin
         WR_flag = (i == 0);
         if (i == d) begin
            ctrl_rd_ack = 1'b1; Ds_from_control = data; tb_oe = 1'b0;
            tick();
            ctrl_rd_ack = 1'b0;
            break;
         end
         Ds_from_control = 8'($urandom);
         if (i == TMO - 1) tb_oe = 1'b0;
         tick();
         if (i < TMO - 1) begin
            checks++; if (Ds !== 8'h00) begin errors++; $display("FAIL ds_wait: got %h expected 00", Ds); end
            checks++; if (rd_timeout !== m_rto) begin errors++; $display("FAIL rto_wait: got %b expected %b", rd_timeout, m_rto); end
            checks++; if (fifo_count !== 3'(cnt0)) begin errors++; $display("FAIL wr_suppress: got %0d expected %0d", fifo_count, cnt0); end
         end
      end
      WR_flag = 1'b0;
      exp = (d < TMO) ? data : 8'hFF;
      if (d >= TMO) m_rto = 1'b1;
      for (int h = 0; h < hold; h++) begin
         checks++; if (Ds !== exp) begin errors++; $display("FAIL ds_drive: got %h expected %h", Ds, exp); end
         checks++; if (rd_timeout !== m_rto) begin errors++; $display("FAIL rto_drive: got %b expected %b", rd_timeout, m_rto); end
         ctrl_rd_ack = 1'($urandom_range(0, 1)); Ds_from_control = 8'($urandom);
         tick();
      end
      checks++; if (Ds !== exp) begin errors++; $display("FAIL ds_hold: got %h expected %h", Ds, exp); end
      ctrl_rd_ack = 1'b0; RD_flag = 1'b0; tb_oe = 1'b1; tb_val = 8'h00;
      #1;
      checks++; if (Ds !== 8'h00) begin errors++; $display("FAIL ds_release: got %h expected 00", Ds); end
      tick();
      checks++; if (Ds !== 8'h00) begin errors++; $display("FAIL ds_idle: got %h expected 00", Ds); end
      checks++; if (fifo_count !== 3'(cnt0)) begin errors++; $display("FAIL rd_count: got %0d expected %0d", fifo_count, cnt0); end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
      checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", wr_valid); end
      checks++; if (Ds_to_Control !== 8'h00) begin errors++; $display("FAIL rst_head: got %h expected 00", Ds_to_Control); end
      checks++; if (RD_flag_control !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", RD_flag_control); end
      checks++; if ({overflow, rd_timeout} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {overflow, rd_timeout}); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      fifo_cycle(1'b1, 8'hF0, 1'b0, 1'b0);
      checks++; if (Ds_to_Control !== 8'hF0) begin errors++; $display("FAIL single_head: got %h expected f0", Ds_to_Control); end
      fifo_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_pop: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         fifo_cycle(1'b1, 8'(i), 1'b0, 1'b0);
         fifo_cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
      end
      checks++; if ({fifo_count, overflow} !== {3'd4, 1'b1}) begin errors++; $display("FAIL ovf_full: got %0d/%b expected 4/1", fifo_count, overflow); end
      for (int i = 1; i <= 4; i++) begin
         checks++; if (Ds_to_Control !== 8'(i)) begin errors++; $display("FAIL ovf_order: got %h expected %h", Ds_to_Control, 8'(i)); end
         fifo_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      fifo_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < DEPTH; i++) begin
         fifo_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
         fifo_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      end
      fifo_cycle(1'b1, 8'hAA, 1'b1, 1'b0);
      checks++; if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin errors++; $display("FAIL b2b_full: got %0d/%b expected 4/0", fifo_count, overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) begin
            checks++; if (Ds_to_Control !== 8'hAA) begin errors++; $display("FAIL b2b_tail: got %h expected aa", Ds_to_Control); end
         end
         fifo_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
   endtask

   task automatic test_level_held();
      int n0;
      n0 = q.size();
      for (int i = 0; i < 4; i++) fifo_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      checks++; if (fifo_count !== 3'(n0 + 1)) begin errors++; $display("FAIL level_held: got %0d expected %0d", fifo_count, n0 + 1); end
      fifo_cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_random_fifo();
      for (int i = 0; i < 300; i++)
         fifo_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 15) == 0));
      for (int i = 0; i <= DEPTH; i++) fifo_cycle(1'b0, 8'h00, 1'b1, 1'b1);
   endtask

   task automatic test_read_ack();
      fifo_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      fifo_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      read_txn(1, 8'h0F, 2);
      for (int k = 0; k < 6; k++)
         read_txn($urandom_range(0, TMO - 1), 8'($urandom_range(1, 255)), $urandom_range(1, 3));
   endtask

   task automatic test_read_timeout();
      read_txn(TMO, 8'h00, 2);
      checks++; if (rd_timeout !== 1'b1) begin errors++; $display("FAIL rto_sticky: got %b expected 1", rd_timeout); end
      fifo_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      fifo_cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_read_abort();
      tb_oe = 1'b1; tb_val = 8'h00; ctrl_rd_ack = 1'b0;
      RD_flag = 1'b1; tick();
      RD_flag = 1'b0; tick();
      checks++; if (RD_flag_control !== 1'b0) begin errors++; $display("FAIL abort_req: got %b expected 0", RD_flag_control); end
      ctrl_rd_ack = 1'b1; Ds_from_control = 8'hC3; tick();
      ctrl_rd_ack = 1'b0; tick();
      checks++; if (Ds !== 8'h00) begin errors++; $display("FAIL idle_ack: got %h expected 00", Ds); end
      RD_flag = 1'b1; tick(); tick(); tick();
      RD_flag = 1'b0; ctrl_rd_ack = 1'b1; Ds_from_control = 8'h5A; tick();
      ctrl_rd_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if ({Ds, RD_flag_control} !== {8'h00, 1'b0}) begin errors++; $display("FAIL abort_wait: got %h/%b expected 00/0", Ds, RD_flag_control); end
         tick();
      end
      read_txn(0, 8'h81, 1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         fifo_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
         fifo_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      end
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_fill: got %0d expected 3", fifo_count); end
      RD_flag = 1'b1; tick(); tick();
      ctrl_rd_ack = 1'b1; Ds_from_control = 8'hE7; tb_oe = 1'b0; tick();
      ctrl_rd_ack = 1'b0;
      checks++; if (Ds !== 8'hE7) begin errors++; $display("FAIL mid_drive: got %h expected e7", Ds); end
      #2;
      rst_n = 1'b0; tb_oe = 1'b1; tb_val = 8'h00;
      #1;
      checks++; if (Ds !== 8'h00) begin errors++; $display("FAIL mid_ds: got %h expected 00", Ds); end
      checks++; if ({fifo_count, wr_valid} !== {3'd0, 1'b0}) begin errors++; $display("FAIL mid_fifo: got %0d/%b expected 0/0", fifo_count, wr_valid); end
      RD_flag = 1'b0;
      q.delete(); m_ovf = 1'b0; m_rto = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      fifo_cycle(1'b1, 8'h07, 1'b0, 1'b0);
      checks++; if (Ds_to_Control !== 8'h07) begin errors++; $display("FAIL post_rst: got %h expected 07", Ds_to_Control); end
`ifdef DATA_BUS_PARITY_EN
      checks++; if (Ds_parity_to_Control !== 1'b0) begin errors++; $display("FAIL parity_07: got %b expected 0", Ds_parity_to_Control); end
`endif
   endtask

   initial begin
      rst_n = 1'b0; RD_flag = 1'b0; WR_flag = 1'b0; ctrl_rd_ack = 1'b0; wr_ready = 1'b0;
      err_clr = 1'b0; tb_oe = 1'b1; tb_val = 8'h00; Ds_from_control = 8'h00;
      m_ovf = 1'b0; m_rto = 1'b0; m_wr_prev = 1'b0;
      test_reset();
      test_single_write();
      test_overflow();
      test_back_to_back();
      test_level_held();
      test_random_fifo();
      test_read_ack();
      test_read_timeout();
      test_read_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
